// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port synchronous data memory: CPU vs host/debug.
// Round-robin on ties, optional host lock, saturating contention counter.
module dmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              host_lock,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  conflict_cnt
);

   // state   | meaning
   // S_IDLE  | waiting for a request; arbitration happens here
   // S_ISSUE | access driven onto the memory, performed on the closing edge
   // S_RESP  | owner's ack high, read data valid on mem_rdata
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic OWN_CPU  = 1'b0;
   localparam logic OWN_HOST = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0] state;
   logic       owner;
   logic       last_owner;
   logic       acc_we;
   logic       both;
   logic       winner;

   always_comb begin
      both   = cpu_req & host_req;
      winner = OWN_CPU;
      if (both) begin
         winner = host_lock ? OWN_HOST : ~last_owner;
      end else if (host_req) begin
         winner = OWN_HOST;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         owner        <= OWN_HOST;
         last_owner   <= OWN_HOST;
         acc_we       <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_ack      <= 1'b0;
         host_ack     <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cpu_ack  <= 1'b0;
               host_ack <= 1'b0;
               if (cpu_req | host_req) begin
                  owner  <= winner;
                  state  <= S_ISSUE;
                  mem_en <= 1'b1;
                  if (winner == OWN_HOST) begin
                     mem_we    <= host_we;
                     acc_we    <= host_we;
                     mem_addr  <= host_addr;
                     mem_wdata <= host_wdata;
                  end else begin
                     mem_we    <= cpu_we;
                     acc_we    <= cpu_we;
                     mem_addr  <= cpu_addr;
                     mem_wdata <= cpu_wdata;
                  end
                  if (both && (conflict_cnt != CNT_MAX)) begin
                     conflict_cnt <= conflict_cnt + CNT_ONE;
                  end
               end else begin
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
               end
            end
            S_ISSUE: begin
               mem_en   <= 1'b0;
               mem_we   <= 1'b0;
               cpu_ack  <= (owner == OWN_CPU);
               host_ack <= (owner == OWN_HOST);
               state    <= S_RESP;
            end
            S_RESP: begin
               cpu_ack    <= 1'b0;
               host_ack   <= 1'b0;
               last_owner <= owner;
               state      <= S_IDLE;
            end
            default: begin
               mem_en   <= 1'b0;
               mem_we   <= 1'b0;
               cpu_ack  <= 1'b0;
               host_ack <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   // Acks are only high in S_RESP for the owner, so they gate the read data directly.
   assign cpu_rdata  = (cpu_ack && !acc_we)  ? mem_rdata : '0;
   assign host_rdata = (host_ack && !acc_we) ? mem_rdata : '0;
   assign cpu_stall  = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory plus a CNT_W=4 instance for saturation.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ack, cpu_stall;
   logic [31:0] cpu_rdata;
   logic        host_req, host_we, host_lock;
   logic [15:0] host_addr;
   logic [31:0] host_wdata;
   logic        host_ack;
   logic [31:0] host_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [15:0] conflict_cnt;

   logic        s_cpu_req, s_host_req;
   logic        s_cpu_ack, s_cpu_stall, s_host_ack, s_mem_en, s_mem_we;
   logic [31:0] s_cpu_rdata, s_host_rdata, s_mem_wdata;
   logic [15:0] s_mem_addr;
   logic [3:0]  s_conflict_cnt;

   logic [31:0] mem_arr [0:255];

   int checks = 0;
   int errors = 0;

   dmem_arbiter u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_lock(host_lock),
      .host_ack(host_ack), .host_rdata(host_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
   );

   dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(s_cpu_req), .cpu_we(1'b0), .cpu_addr(16'h0000), .cpu_wdata(32'h0),
      .cpu_ack(s_cpu_ack), .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
      .host_req(s_host_req), .host_we(1'b0), .host_addr(16'h0001),
      .host_wdata(32'h0), .host_lock(1'b0),
      .host_ack(s_host_ack), .host_rdata(s_host_rdata),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(32'h0), .conflict_cnt(s_conflict_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr[7:0]];
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
      s_cpu_req = 0; s_host_req = 0;
      repeat (2) @(negedge clk);
      checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
      checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
      checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
      checks++; if ({cpu_ack, host_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b exp 00", {cpu_ack, host_ack}); end
      checks++; if (conflict_cnt !== 16'h0) begin errors++; $display("FAIL reset_conflict got %h exp 0", conflict_cnt); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
      rst_n = 1'b1;
   endtask

   task automatic test_cpu_only();
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL cpu_st_issue en/we got %b exp 11", {mem_en, mem_we}); end
      checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL cpu_st_addr got %h exp 0010", mem_addr); end
      checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_st_wdata got %h exp deadbeef", mem_wdata); end
      checks++; if ({cpu_ack, cpu_stall} !== 2'b01) begin errors++; $display("FAIL cpu_st_issue ack/stall got %b exp 01", {cpu_ack, cpu_stall}); end
      cpu_wdata = 32'h0BADF00D;
      @(negedge clk);
      checks++; if ({cpu_ack, host_ack, mem_en} !== 3'b100) begin errors++; $display("FAIL cpu_st_resp ack/hack/en got %b exp 100", {cpu_ack, host_ack, mem_en}); end
      checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL cpu_st_rdata got %h exp 0", cpu_rdata); end
      cpu_req = 0;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
      @(negedge clk);
      checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL cpu_ld_issue en/we got %b exp 10", {mem_en, mem_we}); end
      @(negedge clk);
      checks++; if ({cpu_ack, host_ack} !== 2'b10) begin errors++; $display("FAIL cpu_ld_resp acks got %b exp 10", {cpu_ack, host_ack}); end
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_ld_rdata got %h exp deadbeef", cpu_rdata); end
      checks++; if (conflict_cnt !== 16'h0) begin errors++; $display("FAIL cpu_only_conflict got %h exp 0", conflict_cnt); end
      cpu_req = 0;
      @(negedge clk);
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_ack_width got %b exp 0", cpu_ack); end
   endtask

   task automatic test_tie();
      do_reset();
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
      host_req = 1; host_we = 1; host_addr = 16'h0011; host_wdata = 32'h12345678; host_lock = 0;
      @(negedge clk);
      checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL tie1_winner addr got %h exp 0010", mem_addr); end
      checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL tie1_conflict got %0d exp 1", conflict_cnt); end
      @(negedge clk);
      checks++; if ({cpu_ack, host_ack} !== 2'b10) begin errors++; $display("FAIL tie1_acks got %b exp 10", {cpu_ack, host_ack}); end
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL tie1_rdata got %h exp deadbeef", cpu_rdata); end
      checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL tie1_host_rdata got %h exp 0", host_rdata); end
      cpu_req = 0;
      repeat (2) @(negedge clk);
      checks++; if ({mem_we, mem_addr} !== {1'b1, 16'h0011}) begin errors++; $display("FAIL host2_access we/addr got %b/%h exp 1/0011", mem_we, mem_addr); end
      checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL host2_wdata got %h exp 12345678", mem_wdata); end
      @(negedge clk);
      checks++; if ({cpu_ack, host_ack} !== 2'b01) begin errors++; $display("FAIL host2_acks got %b exp 01", {cpu_ack, host_ack}); end
      checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL host2_wr_rdata got %h exp 0", host_rdata); end
      host_req = 0;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0011;
      host_req = 1; host_we = 0; host_addr = 16'h0010;
      @(negedge clk);
      checks++; if (mem_addr !== 16'h0011) begin errors++; $display("FAIL tie2_winner addr got %h exp 0011", mem_addr); end
      checks++; if (conflict_cnt !== 16'd2) begin errors++; $display("FAIL tie2_conflict got %0d exp 2", conflict_cnt); end
      @(negedge clk);
      checks++; if ({cpu_ack, host_ack} !== 2'b10) begin errors++; $display("FAIL tie2_acks got %b exp 10", {cpu_ack, host_ack}); end
      checks++; if (cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL tie2_rdata got %h exp 12345678", cpu_rdata); end
      cpu_req = 0;
      repeat (3) @(negedge clk);
      checks++; if ({cpu_ack, host_ack} !== 2'b01) begin errors++; $display("FAIL host3_acks got %b exp 01", {cpu_ack, host_ack}); end
      checks++; if (host_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL host3_rdata got %h exp deadbeef", host_rdata); end
      checks++; if (conflict_cnt !== 16'd2) begin errors++; $display("FAIL host3_conflict got %0d exp 2", conflict_cnt); end
      host_req = 0;
      @(negedge clk);
   endtask

   task automatic test_host_lock();
      int h = 0;
      int stall_cnt;
      int cpu_ack_cyc = -1;
      @(negedge clk);
      host_req = 1; host_lock = 1; host_we = 1; host_addr = 16'h0000; host_wdata = 32'h000000A0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0002;
      #1;
      stall_cnt = int'(cpu_stall);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         stall_cnt += int'(cpu_stall);
         if (host_ack) begin
            h++;
            checks++; if (i != 3 * h - 1) begin errors++; $display("FAIL lock_host_ack_cycle got %0d exp %0d", i, 3 * h - 1); end
            if (h < 4) begin
               host_addr = 16'(h);
               host_wdata = 32'h000000A0 + 32'(h);
            end else begin
               host_req = 0;
            end
         end
         if (cpu_ack) begin
            cpu_ack_cyc = i;
            checks++; if (cpu_rdata !== 32'h000000A2) begin errors++; $display("FAIL lock_cpu_rdata got %h exp 000000a2", cpu_rdata); end
            cpu_req = 0;
         end
      end
      host_lock = 0;
      checks++; if (h != 4) begin errors++; $display("FAIL lock_host_acks got %0d exp 4", h); end
      checks++; if (cpu_ack_cyc != 14) begin errors++; $display("FAIL lock_cpu_ack_cycle got %0d exp 14", cpu_ack_cyc); end
      checks++; if (stall_cnt != 14) begin errors++; $display("FAIL lock_stall_cycles got %0d exp 14", stall_cnt); end
      checks++; if (conflict_cnt !== 16'd6) begin errors++; $display("FAIL lock_conflict got %0d exp 6", conflict_cnt); end
   endtask

   task automatic test_pulse();
      int extra = 0;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0011;
      @(negedge clk);
      checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0011}) begin errors++; $display("FAIL pulse_issue en/addr got %b/%h exp 1/0011", mem_en, mem_addr); end
      cpu_req = 0; cpu_addr = 16'h0003;
      @(negedge clk);
      checks++; if ({cpu_ack, cpu_stall} !== 2'b10) begin errors++; $display("FAIL pulse_ack/stall got %b exp 10", {cpu_ack, cpu_stall}); end
      checks++; if (cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL pulse_rdata got %h exp 12345678", cpu_rdata); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         extra += int'(cpu_ack) + int'(mem_en);
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL pulse_no_second_access got %0d exp 0", extra); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 32'h11112222;
      repeat (2) @(negedge clk);
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rmid_prestore_ack got %b exp 1", cpu_ack); end
      cpu_req = 0;
      @(negedge clk);
      host_req = 1; host_we = 1; host_addr = 16'h0020; host_wdata = 32'hBAD0BAD0;
      @(negedge clk);
      checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL rmid_issue en/we got %b exp 11", {mem_en, mem_we}); end
      rst_n = 0;
      #1;
      checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL rmid_async en/we got %b exp 00", {mem_en, mem_we}); end
      host_req = 0;
      @(negedge clk);
      checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rmid_ack_in_reset got %b exp 0", host_ack); end
      rst_n = 1;
      @(negedge clk);
      checks++; if ({host_ack, conflict_cnt} !== 17'h0) begin errors++; $display("FAIL rmid_after ack/conflict got %b/%h exp 0/0", host_ack, conflict_cnt); end
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
      repeat (2) @(negedge clk);
      checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 32'h11112222}) begin errors++; $display("FAIL rmid_readback ack/rdata got %b/%h exp 1/11112222", cpu_ack, cpu_rdata); end
      cpu_req = 0;
      @(negedge clk);
   endtask

   task automatic test_saturate();
      @(negedge clk);
      s_cpu_req = 1; s_host_req = 1;
      repeat (40) @(negedge clk);
      checks++; if (s_conflict_cnt !== 4'd14) begin errors++; $display("FAIL sat_mid got %0d exp 14", s_conflict_cnt); end
      repeat (18) @(negedge clk);
      checks++; if (s_conflict_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got %h exp f", s_conflict_cnt); end
      s_cpu_req = 0; s_host_req = 0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
      mem_rdata = 32'h0;
      test_reset();
      test_cpu_only();
      test_tie();
      test_host_lock();
      test_pulse();
      test_reset_mid();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
